// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator stream driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state type, skid FIFO depth, default datapath widths.
package acc_pkg;

  // Driver sequencing: one clear cycle, a stream of beats, one done cycle.
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DONE
  } acc_drv_state_t;

  // Two entries cover the 1-cycle read latency: one beat waiting at the
  // accumulator plus one read that was already in flight when it stalled.
  localparam int ACC_FIFO_DEPTH = 2;

  localparam int ACC_WIDTH  = 32;
  localparam int ACC_ADDR_W = 10;
  localparam int ACC_LEN_W  = 10;

endpackage

// File: rtl/acc_skid_fifo.sv
// Small FIFO that parks operand reads while the accumulator stalls.
// Latency: pushed data visible at head the cycle after the push.
// Backpressure: none internally; the producer must never push when full.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        write push_data at the tail (ignored when full)
//   push_data   entry to write
//   pop         drop the head entry (ignored when empty)
//   full/empty  occupancy flags
//   head        oldest entry (stable until popped)
module acc_skid_fifo
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int DEPTH = ACC_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic do_push;
  logic do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer wrap written explicitly so non-power-of-two depths also work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/acc_stream_driver.sv
// Reads a job's operands from the operand buffer and streams them to the accumulator.
// Latency: clear 1 cycle after start, first beat 3 cycles after start, done 1 cycle after last beat.
// Backpressure: acc_ready low holds the current beat; reads stop once FIFO plus in-flight read fill 2 slots.
// Optional build macro: ACC_DRV_STRIDE_EN adds a stride input (element i at base + i*stride);
// without it the stride is fixed at 1.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start            job request, sampled only while idle
//   base_addr        first operand address, captured with start
//   length           operand count, captured with start (0 = clear only)
//   stride           (ACC_DRV_STRIDE_EN only) address step, captured with start
//   busy, done       job in progress / 1-cycle completion pulse
//   buf_rd_en        operand buffer read strobe
//   buf_addr         operand buffer read address
//   buf_rd_data      read data, valid the cycle after buf_rd_en
//   acc_clear        1-cycle accumulator clear
//   acc_in           operand beat
//   acc_valid        beat valid
//   acc_ready        accumulator accepts the beat
//   acc_last         marks the final beat of the job
module acc_stream_driver
  import acc_pkg::*;
#(
  parameter int WIDTH  = ACC_WIDTH,
  parameter int ADDR_W = ACC_ADDR_W,
  parameter int LEN_W  = ACC_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
`ifdef ACC_DRV_STRIDE_EN
  input  logic [ADDR_W-1:0] stride,
`endif
  output logic              busy,
  output logic              done,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [WIDTH-1:0]  buf_rd_data,
  output logic              acc_clear,
  output logic [WIDTH-1:0]  acc_in,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              acc_last
);

  acc_drv_state_t    state_q;
  acc_drv_state_t    state_d;

  logic [ADDR_W-1:0] addr_q;        // address of the next read to issue
  logic [ADDR_W-1:0] stride_v;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  reads_left_q;
  logic [LEN_W-1:0]  beats_sent_q;
  logic              inflight_q;    // a read was issued last cycle; its data is on buf_rd_data now

  logic              start_ok;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WIDTH-1:0]  fifo_head;
  logic              fifo_push;
  logic              fifo_pop;
  logic              beat_hs;
  logic              last_hs;

  assign start_ok = (state_q == S_IDLE) && start;

  // ---------------------------------------------------------------------------
  // Stride: captured per job when enabled, otherwise a constant unit step.
  // ---------------------------------------------------------------------------
`ifdef ACC_DRV_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stride_q <= '0;
    end else if (start_ok) begin
      stride_q <= stride;
    end
  end

  assign stride_v = stride_q;
`else
  assign stride_v = ADDR_W'(1);
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_CLEAR;
      // A zero-length job only clears the accumulator.
      S_CLEAR:  state_d = (len_q == '0) ? S_DONE : S_STREAM;
      S_STREAM: if (last_hs) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign acc_clear = (state_q == S_CLEAR);

  // ---------------------------------------------------------------------------
  // Read issue. Data held by the driver = FIFO entries + the in-flight read.
  // With a 2-entry FIFO a new read is safe unless that total is already 2:
  // either the FIFO is full, or it holds one entry and a read is in flight.
  // ---------------------------------------------------------------------------
  assign buf_rd_en = (state_q == S_STREAM) &&
                     (reads_left_q != '0) &&
                     !fifo_full &&
                     !(inflight_q && !fifo_empty);
  assign buf_addr  = addr_q;

  // ---------------------------------------------------------------------------
  // Beat path. When the FIFO is empty the returning read data is presented
  // directly, so the first beat appears the cycle its data arrives. The data
  // only enters the FIFO if it cannot be consumed in that same cycle.
  // ---------------------------------------------------------------------------
  assign acc_valid = !fifo_empty || inflight_q;
  assign acc_in    = !acc_valid  ? '0 :
                     fifo_empty  ? buf_rd_data : fifo_head;
  assign acc_last  = acc_valid && (state_q == S_STREAM) &&
                     (beats_sent_q == len_q - LEN_W'(1));

  assign beat_hs   = acc_valid && acc_ready;
  assign last_hs   = beat_hs && acc_last;

  assign fifo_pop  = beat_hs && !fifo_empty;
  assign fifo_push = inflight_q && !(fifo_empty && acc_ready);

  acc_skid_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (ACC_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (buf_rd_data),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // ---------------------------------------------------------------------------
  // State, job registers and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      reads_left_q <= '0;
      beats_sent_q <= '0;
      inflight_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= buf_rd_en;
      if (start_ok) begin
        // Job parameters are captured only here; start while busy never reaches this.
        addr_q       <= base_addr;
        len_q        <= length;
        reads_left_q <= length;
        beats_sent_q <= '0;
      end else begin
        if (buf_rd_en) begin
          // Running sum gives base + i*stride with natural modulo-2^ADDR_W wrap.
          addr_q       <= addr_q + stride_v;
          reads_left_q <= reads_left_q - LEN_W'(1);
        end
        if (beat_hs) begin
          beats_sent_q <= beats_sent_q + LEN_W'(1);
        end
      end
    end
  end

endmodule
